// File: rtl/sap_mem_pkg.sv
// Shared widths and FSM encoding for the program-memory access controller.
package sap_mem_pkg;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 2 ** ADDR_W;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CPU_RD  = 3'd1,
    ST_CPU_WR  = 3'd2,
    ST_LD_WAIT = 3'd3,
    ST_LD_WR   = 3'd4,
    ST_VFY_RD  = 3'd5,
    ST_VFY_END = 3'd6
  } state_e;

  // States in which the loader owns the memory and the CPU is held off.
  function automatic logic is_load_state(input state_e s);
    logic r;
    case (s)
      ST_LD_WAIT, ST_LD_WR, ST_VFY_RD, ST_VFY_END: r = 1'b1;
      default:                                     r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// CPU, loader and memory-side signals of the access controller; slave = controller side.
interface mem_access_ctrl_if;
  import sap_mem_pkg::*;

  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_adr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_ack;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_hold;
  logic              ld_start;
  logic              ld_valid;
  logic [DATA_W-1:0] ld_data;
  logic              ld_ready;
  logic              ld_busy;
  logic              ld_done;
  logic              ld_err;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_adr;
  logic [DATA_W-1:0] mem_data_in;
  logic [DATA_W-1:0] mem_value;

  modport slave (
    input  cpu_req, cpu_we, cpu_adr, cpu_wdata, ld_start, ld_valid, ld_data, mem_value,
    output cpu_ack, cpu_rdata, cpu_hold, ld_ready, ld_busy, ld_done, ld_err,
           mem_write, mem_adr, mem_data_in
  );

  modport master (
    output cpu_req, cpu_we, cpu_adr, cpu_wdata, ld_start, ld_valid, ld_data, mem_value,
    input  cpu_ack, cpu_rdata, cpu_hold, ld_ready, ld_busy, ld_done, ld_err,
           mem_write, mem_adr, mem_data_in
  );

endinterface

// File: rtl/mem_access_ctrl_chk.sv
// Protocol checks for the CPU side of the access controller.
module mem_access_ctrl_chk
  import sap_mem_pkg::*;
(
  input logic              clk,
  input logic              rst_n,
  input logic              cpu_req_i,
  input logic              cpu_we_i,
  input logic [ADDR_W-1:0] cpu_adr_i,
  input logic              cpu_ack_i,
  input logic              cpu_hold_i
);

  a_req_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (cpu_req_i && $past(cpu_req_i) && !$past(cpu_ack_i)) |-> ($stable(cpu_adr_i) && $stable(cpu_we_i)));

  a_no_ack_in_hold: assert property (@(posedge clk) disable iff (!rst_n)
    !(cpu_ack_i && cpu_hold_i));

  a_no_b2b_ack: assert property (@(posedge clk) disable iff (!rst_n)
    cpu_ack_i |=> !cpu_ack_i);

endmodule

// File: rtl/mem_xor_sum.sv
// Byte-wide XOR accumulator with synchronous clear; used for the write and readback checksums.
module mem_xor_sum
  import sap_mem_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear_i,
  input  logic              en_i,
  input  logic [DATA_W-1:0] din_i,
  output logic [DATA_W-1:0] sum_o
);

  logic [DATA_W-1:0] sum_q;

  // Clear wins over accumulate so a new burst never inherits a stale sum.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sum_q <= DATA_W'(0);
    end else if (clear_i) begin
      sum_q <= DATA_W'(0);
    end else if (en_i) begin
      sum_q <= sum_q ^ din_i;
    end else begin
      sum_q <= sum_q;
    end
  end

  assign sum_o = sum_q;

endmodule

// File: rtl/mem_access_ctrl.sv
// Shares the single-port program memory between CPU accesses and the byte loader.
// Writes are paced by clken; each load is read back and checked against its XOR checksum.
module mem_access_ctrl
  import sap_mem_pkg::*;
#(
  parameter int LOAD_LEN = 16
) (
  input  logic             sysclk,
  input  logic             rst_n,
  input  logic             clken,
  mem_access_ctrl_if.slave bus
);

  localparam int LEN_C = (LOAD_LEN < 1) ? 1 : ((LOAD_LEN > DEPTH) ? DEPTH : LOAD_LEN);
  localparam logic [ADDR_W-1:0] ADR_ZERO  = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] ADR_ONE   = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] ADR_LAST  = ADDR_W'(LEN_C - 1);
  localparam logic [ADDR_W:0]   VCYC_ZERO = (ADDR_W + 1)'(0);
  localparam logic [ADDR_W:0]   VCYC_ONE  = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W:0]   VCYC_LAST = (ADDR_W + 1)'(LEN_C);

  state_e            state_q, state_d;
  logic              rd_phase_q, rd_phase_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] adr_q, adr_d;
  logic [ADDR_W:0]   vcyc_q, vcyc_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              mem_write_q, mem_write_d;
  logic              ack_q, ack_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              wsum_clr, wsum_en, rsum_clr, rsum_en;
  logic [DATA_W-1:0] wsum, rsum;

  mem_xor_sum u_wsum (
    .clk(sysclk), .rst_n(rst_n), .clear_i(wsum_clr), .en_i(wsum_en),
    .din_i(bus.ld_data), .sum_o(wsum)
  );

  mem_xor_sum u_rsum (
    .clk(sysclk), .rst_n(rst_n), .clear_i(rsum_clr), .en_i(rsum_en),
    .din_i(bus.mem_value), .sum_o(rsum)
  );

  // Next-state and registered-output decode.
  always_comb begin
    state_d     = state_q;
    rd_phase_d  = rd_phase_q;
    cnt_d       = cnt_q;
    adr_d       = adr_q;
    vcyc_d      = vcyc_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    mem_write_d = mem_write_q;
    ack_d       = 1'b0;
    ready_d     = 1'b0;
    done_d      = 1'b0;
    err_d       = err_q;
    wsum_clr    = 1'b0;
    wsum_en     = 1'b0;
    rsum_clr    = 1'b0;
    rsum_en     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.ld_start) begin
          state_d  = ST_LD_WAIT;
          cnt_d    = ADR_ZERO;
          adr_d    = ADR_ZERO;
          ready_d  = 1'b1;
          wsum_clr = 1'b1;
        end else if (bus.cpu_req) begin
          adr_d   = bus.cpu_adr;
          wdata_d = bus.cpu_wdata;
          if (bus.cpu_we) begin
            state_d     = ST_CPU_WR;
            mem_write_d = 1'b1;
          end else begin
            state_d    = ST_CPU_RD;
            rd_phase_d = 1'b0;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      // Phase 0 lets the registered memory see the address; phase 1 takes its output.
      ST_CPU_RD: begin
        if (rd_phase_q) begin
          rdata_d    = bus.mem_value;
          ack_d      = 1'b1;
          rd_phase_d = 1'b0;
          state_d    = ST_IDLE;
        end else begin
          rd_phase_d = 1'b1;
        end
      end

      ST_CPU_WR: begin
        if (clken) begin
          mem_write_d = 1'b0;
          ack_d       = 1'b1;
          state_d     = ST_IDLE;
        end else begin
          mem_write_d = 1'b1;
        end
      end

      ST_LD_WAIT: begin
        if (bus.ld_valid && ready_q) begin
          wdata_d     = bus.ld_data;
          wsum_en     = 1'b1;
          mem_write_d = 1'b1;
          state_d     = ST_LD_WR;
        end else begin
          ready_d = 1'b1;
        end
      end

      ST_LD_WR: begin
        if (clken) begin
          mem_write_d = 1'b0;
          if (cnt_q == ADR_LAST) begin
            state_d  = ST_VFY_RD;
            vcyc_d   = VCYC_ZERO;
            adr_d    = ADR_ZERO;
            rsum_clr = 1'b1;
          end else begin
            cnt_d   = cnt_q + ADR_ONE;
            adr_d   = cnt_q + ADR_ONE;
            ready_d = 1'b1;
            state_d = ST_LD_WAIT;
          end
        end else begin
          mem_write_d = 1'b1;
        end
      end

      // Cycle k presents address min(k, LEN-1) and folds in the word addressed in cycle k-1.
      ST_VFY_RD: begin
        rsum_en = (vcyc_q != VCYC_ZERO);
        if (vcyc_q == VCYC_LAST) begin
          state_d = ST_VFY_END;
        end else begin
          vcyc_d = vcyc_q + VCYC_ONE;
          if (adr_q != ADR_LAST) begin
            adr_d = adr_q + ADR_ONE;
          end else begin
            adr_d = adr_q;
          end
        end
      end

      ST_VFY_END: begin
        err_d   = (rsum != wsum);
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end

      default: begin
        state_d     = ST_IDLE;
        mem_write_d = 1'b0;
      end
    endcase

    busy_d = is_load_state(state_d);
  end

  // State and output registers.
  always_ff @(posedge sysclk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      rd_phase_q  <= 1'b0;
      cnt_q       <= ADR_ZERO;
      adr_q       <= ADR_ZERO;
      vcyc_q      <= VCYC_ZERO;
      wdata_q     <= DATA_W'(0);
      rdata_q     <= DATA_W'(0);
      mem_write_q <= 1'b0;
      ack_q       <= 1'b0;
      ready_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_phase_q  <= rd_phase_d;
      cnt_q       <= cnt_d;
      adr_q       <= adr_d;
      vcyc_q      <= vcyc_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      mem_write_q <= mem_write_d;
      ack_q       <= ack_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign bus.cpu_ack     = ack_q;
  assign bus.cpu_rdata   = rdata_q;
  assign bus.cpu_hold    = busy_q;
  assign bus.ld_ready    = ready_q;
  assign bus.ld_busy     = busy_q;
  assign bus.ld_done     = done_q;
  assign bus.ld_err      = err_q;
  assign bus.mem_write   = mem_write_q;
  assign bus.mem_adr     = adr_q;
  assign bus.mem_data_in = wdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a behavioural 16x8 registered-read memory.
module tb_mem_access_ctrl;
  import sap_mem_pkg::*;

  logic sysclk = 1'b0;
  logic rst_n;
  logic clken;
  int   clk_per = 0;
  int   clk_div = 0;
  logic corrupt5;
  logic clken_at_edge;
  logic [7:0] mem_m [16];

  int total = 0;
  int bad   = 0;
  logic mon_on = 1'b0;
  int done_cnt, busy_low, ack_in_load;

  mem_access_ctrl_if bus();

  mem_access_ctrl #(.LOAD_LEN(16)) dut (
    .sysclk(sysclk), .rst_n(rst_n), .clken(clken), .bus(bus)
  );

  mem_access_ctrl_chk u_chk (
    .clk(sysclk), .rst_n(rst_n), .cpu_req_i(bus.cpu_req), .cpu_we_i(bus.cpu_we),
    .cpu_adr_i(bus.cpu_adr), .cpu_ack_i(bus.cpu_ack), .cpu_hold_i(bus.cpu_hold)
  );

  logic [27:0] outs_v;
  assign outs_v = {bus.cpu_ack, bus.cpu_rdata, bus.cpu_hold, bus.ld_ready, bus.ld_busy,
                   bus.ld_done, bus.ld_err, bus.mem_write, bus.mem_adr, bus.mem_data_in};

  always #5 sysclk = ~sysclk;

  always @(negedge sysclk) begin
    if (clk_per == 0) begin
      clken = 1'b0;
    end else begin
      clk_div = (clk_div + 1) % clk_per;
      clken   = (clk_div == 0);
    end
  end

  always @(posedge sysclk) begin
    clken_at_edge <= clken;
    if (bus.mem_write && clken) mem_m[bus.mem_adr] <= bus.mem_data_in;
    bus.mem_value <= mem_m[bus.mem_adr] ^ ((corrupt5 && bus.mem_adr == 4'd5) ? 8'h01 : 8'h00);
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge sysclk);
    if (mon_on) begin
      if (bus.ld_done) done_cnt++;
      else if (!bus.ld_busy || !bus.cpu_hold) busy_low++;
      if (bus.cpu_ack) ack_in_load++;
    end
  endtask

  task automatic wait_ack(output int cycles, output int mw_hi);
    cycles = 0;
    mw_hi  = 0;
    while (cycles < 100) begin
      tick();
      cycles++;
      if (bus.cpu_ack) break;
      if (bus.mem_write) mw_hi++;
    end
  endtask

  task automatic start_load(input logic with_rd);
    bus.ld_start = 1'b1;
    if (with_rd) begin
      bus.cpu_req = 1'b1;
      bus.cpu_we  = 1'b0;
      bus.cpu_adr = 4'd0;
    end
    tick();
    bus.ld_start = 1'b0;
    done_cnt = 0;
    busy_low = 0;
    ack_in_load = 0;
    mon_on = 1'b1;
  endtask

  task automatic wait_ready();
    int t;
    t = 0;
    while (!bus.ld_ready && t < 200) begin
      tick();
      t++;
    end
    check_val("ld_ready_timeout", 32'(t < 200), 32'd1);
  endtask

  task automatic feed_bytes(input logic [7:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 2)) tick();
      wait_ready();
      bus.ld_valid = 1'b1;
      bus.ld_data  = base + 8'(i);
      tick();
      bus.ld_valid = 1'b0;
    end
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while (!bus.ld_done && t < 1000) begin
      tick();
      t++;
    end
    mon_on = 1'b0;
    check_val("ld_done_seen", 32'(bus.ld_done), 32'd1);
  endtask

  function automatic int mem_errs(input logic [7:0] base);
    int n;
    n = 0;
    for (int i = 0; i < 16; i++) begin
      if (mem_m[i] !== base + 8'(i)) n++;
    end
    return n;
  endfunction

  initial begin
    int cyc, mw, acks;
    rst_n = 1'b0;
    clken = 1'b0;
    corrupt5 = 1'b0;
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_adr = 4'd0; bus.cpu_wdata = 8'h00;
    bus.ld_start = 1'b0; bus.ld_valid = 1'b0; bus.ld_data = 8'h00;
    for (int i = 0; i < 16; i++) mem_m[i] = 8'h77;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    check_val("reset_outputs", 32'(outs_v), 32'd0);

    // 1: reset in the middle of a stalled CPU write
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_adr = 4'd7; bus.cpu_wdata = 8'h3C;
    repeat (4) tick();
    check_val("t1_mw_stalled", 32'(bus.mem_write), 32'd1);
    check_val("t1_mem_adr", 32'(bus.mem_adr), 32'd7);
    rst_n = 1'b0;
    repeat (2) tick();
    check_val("t1_outputs_cleared", 32'(outs_v), 32'd0);
    check_val("t1_mem7_untouched", 32'(mem_m[7]), 32'h77);
    bus.cpu_req = 1'b0;
    rst_n = 1'b1;
    tick();

    // 2: paced CPU write then a read of the same address
    clk_per = 4;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_adr = 4'd3; bus.cpu_wdata = 8'hA5;
    wait_ack(cyc, mw);
    check_val("t2_wr_ack", 32'(bus.cpu_ack), 32'd1);
    check_val("t2_mw_held", 32'(mw), 32'(cyc - 1));
    check_val("t2_commit_on_clken", 32'(clken_at_edge), 32'd1);
    check_val("t2_mem3", 32'(mem_m[3]), 32'hA5);
    check_val("t2_mw_dropped", 32'(bus.mem_write), 32'd0);
    bus.cpu_req = 1'b0;
    acks = 0;
    repeat (4) begin
      tick();
      if (bus.cpu_ack) acks++;
    end
    check_val("t2_single_ack", 32'(acks), 32'd0);
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_adr = 4'd3;
    wait_ack(cyc, mw);
    check_val("t2_rd_latency", 32'(cyc), 32'd3);
    check_val("t2_rdata", 32'(bus.cpu_rdata), 32'hA5);
    bus.cpu_req = 1'b0;
    tick();

    // 3: full load of 0x00..0x0F with random valid gaps
    clk_per = 3;
    start_load(1'b0);
    feed_bytes(8'h00, 16);
    wait_done();
    check_val("t3_done_count", 32'(done_cnt), 32'd1);
    check_val("t3_err", 32'(bus.ld_err), 32'd0);
    check_val("t3_busy_gaps", 32'(busy_low), 32'd0);
    tick();
    check_val("t3_done_pulse", 32'(bus.ld_done), 32'd0);
    check_val("t3_busy_after", 32'(bus.ld_busy), 32'd0);
    check_val("t3_mem_image", 32'(mem_errs(8'h00)), 32'd0);

    // 4: ld_start and a CPU read in the same IDLE cycle
    start_load(1'b1);
    feed_bytes(8'h00, 16);
    wait_done();
    check_val("t4_done_count", 32'(done_cnt), 32'd1);
    check_val("t4_hold_gaps", 32'(busy_low), 32'd0);
    check_val("t4_ack_in_hold", 32'(ack_in_load), 32'd0);
    wait_ack(cyc, mw);
    check_val("t4_rd_latency", 32'(cyc), 32'd3);
    check_val("t4_rdata", 32'(bus.cpu_rdata), 32'h00);
    bus.cpu_req = 1'b0;
    tick();

    // 5: corrupted readback of address 5
    corrupt5 = 1'b1;
    start_load(1'b0);
    feed_bytes(8'h20, 16);
    wait_done();
    check_val("t5_err", 32'(bus.ld_err), 32'd1);
    check_val("t5_done_count", 32'(done_cnt), 32'd1);
    corrupt5 = 1'b0;
    tick();

    // 6: reset after seven bytes, then a fresh burst
    start_load(1'b0);
    feed_bytes(8'hE0, 7);
    wait_ready();
    check_val("t6_mem6_written", 32'(mem_m[6]), 32'hE6);
    check_val("t6_mem7_old", 32'(mem_m[7]), 32'h27);
    rst_n = 1'b0;
    repeat (2) tick();
    mon_on = 1'b0;
    check_val("t6_no_partial_done", 32'(done_cnt), 32'd0);
    check_val("t6_busy_cleared", 32'(bus.ld_busy), 32'd0);
    check_val("t6_outputs_cleared", 32'(outs_v), 32'd0);
    rst_n = 1'b1;
    tick();
    start_load(1'b0);
    feed_bytes(8'h50, 16);
    wait_done();
    check_val("t6_err", 32'(bus.ld_err), 32'd0);
    check_val("t6_done_count", 32'(done_cnt), 32'd1);
    check_val("t6_mem0", 32'(mem_m[0]), 32'h50);
    check_val("t6_mem_image", 32'(mem_errs(8'h50)), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
